// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, key-rotation schedule, S-box contents,
// bit-numbered permute helpers and the round-engine state encoding.
package des_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam int unsigned BLOCK_W = 64;
   localparam int unsigned HALF_W  = 32;
   localparam int unsigned CD_W    = 28;
   localparam int unsigned KEY_W   = 48;

   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int unsigned FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Each box flattened as row*16+col, row = {b1,b6}, col = b2..b5
   localparam logic [3:0] SBOX [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   // Table entries are DES bit numbers: bit 1 is the MSB of the source vector
   function automatic logic [63:0] ip_perm(input logic [63:0] d);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[6'(63 - i)] = d[6'(64 - IP_T[i])];
      return r;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] d);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[6'(63 - i)] = d[6'(64 - FP_T[i])];
      return r;
   endfunction

   function automatic logic [47:0] e_perm(input logic [31:0] d);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = d[5'(32 - E_T[i])];
      return r;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] d);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[5'(31 - i)] = d[5'(32 - P_T[i])];
      return r;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] d);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = d[6'(64 - PC1_T[i])];
      return r;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] d);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = d[6'(56 - PC2_T[i])];
      return r;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int unsigned s);
      return (s == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int unsigned s);
      return (s == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] idx);
      return SBOX[box][{idx[5], idx[0], idx[4:1]}];
   endfunction

endpackage

// File: rtl/des_f_function.sv
// Combinational DES round function: f = P(S(E(R) ^ K)).
module des_f_function import des_pkg::*; (
   input  logic [31:0] i_r,
   input  logic [47:0] i_k,
   output logic [31:0] o_f_c
);
   logic [47:0] w_x;
   logic [31:0] w_s;

   assign w_x = e_perm(i_r) ^ i_k;

   s_box_1 u_s1 (.i_idx(w_x[47:42]), .o_val_c(w_s[31:28]));
   s_box_2 u_s2 (.i_idx(w_x[41:36]), .o_val_c(w_s[27:24]));
   s_box_3 u_s3 (.i_idx(w_x[35:30]), .o_val_c(w_s[23:20]));
   s_box_4 u_s4 (.i_idx(w_x[29:24]), .o_val_c(w_s[19:16]));
   s_box_5 u_s5 (.i_idx(w_x[23:18]), .o_val_c(w_s[15:12]));
   s_box_6 u_s6 (.i_idx(w_x[17:12]), .o_val_c(w_s[11:8]));
   s_box_7 u_s7 (.i_idx(w_x[11:6]),  .o_val_c(w_s[7:4]));
   s_box_8 u_s8 (.i_idx(w_x[5:0]),   .o_val_c(w_s[3:0]));

   assign o_f_c = p_perm(w_s);
endmodule

// File: rtl/s_box_1.sv
// DES S-box S1: 6-bit index to 4-bit substitution.
module s_box_1 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd0, i_idx);
endmodule

// File: rtl/s_box_2.sv
// DES S-box S2: 6-bit index to 4-bit substitution.
module s_box_2 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd1, i_idx);
endmodule

// File: rtl/s_box_3.sv
// DES S-box S3: 6-bit index to 4-bit substitution.
module s_box_3 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd2, i_idx);
endmodule

// File: rtl/s_box_4.sv
// DES S-box S4: 6-bit index to 4-bit substitution.
module s_box_4 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd3, i_idx);
endmodule

// File: rtl/s_box_5.sv
// DES S-box S5: 6-bit index to 4-bit substitution.
module s_box_5 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd4, i_idx);
endmodule

// File: rtl/s_box_6.sv
// DES S-box S6: 6-bit index to 4-bit substitution.
module s_box_6 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd5, i_idx);
endmodule

// File: rtl/s_box_7.sv
// DES S-box S7: 6-bit index to 4-bit substitution.
module s_box_7 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd6, i_idx);
endmodule

// File: rtl/s_box_8.sv
// DES S-box S8: 6-bit index to 4-bit substitution.
module s_box_8 import des_pkg::*; (
   input  logic [5:0] i_idx,
   output logic [3:0] o_val_c
);
   assign o_val_c = sbox_lookup(3'd7, i_idx);
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES ECB engine: one Feistel round per clock, on-the-fly key schedule,
// valid/ready on both sides.
module des_round_engine import des_pkg::*; #(
   parameter int unsigned ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   input  logic [63:0] in_key,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);
   state_t      r_state, w_state_nx;
   logic        w_load, w_step, w_finish;
   logic        r_in_ready, r_out_valid, r_busy;
   logic [63:0] r_out_data;
   logic [31:0] r_l, r_r;
   logic [27:0] r_c, r_d;
   logic [4:0]  r_rnd;
   logic        r_dec;

   logic        w_last;
   logic [3:0]  w_shift_idx;
   logic [27:0] w_c_rotl, w_d_rotl, w_c_nx, w_d_nx;
   logic [47:0] w_k;
   logic [31:0] w_f, w_r_nx;
   logic [63:0] w_ip;
   logic [55:0] w_pc1;
   logic        w_unused_parity;

   assign w_ip  = ip_perm(in_data);
   assign w_pc1 = pc1_perm(in_key);
   // Parity bits are dropped by PC1
   assign w_unused_parity = ^{in_key[56], in_key[48], in_key[40], in_key[32],
                              in_key[24], in_key[16], in_key[8],  in_key[0]};

   // Encrypt rotates left before PC2; decrypt uses current C,D then rotates right
   assign w_last      = (r_rnd == 5'(ROUNDS));
   assign w_shift_idx = r_dec ? 4'(5'd16 - r_rnd) : 4'(r_rnd - 5'd1);
   assign w_c_rotl    = rotl28(r_c, SHIFTS[w_shift_idx]);
   assign w_d_rotl    = rotl28(r_d, SHIFTS[w_shift_idx]);
   assign w_k         = r_dec ? pc2_perm({r_c, r_d}) : pc2_perm({w_c_rotl, w_d_rotl});
   assign w_c_nx      = r_dec ? rotr28(r_c, SHIFTS[w_shift_idx]) : w_c_rotl;
   assign w_d_nx      = r_dec ? rotr28(r_d, SHIFTS[w_shift_idx]) : w_d_rotl;

   des_f_function u_f (
      .i_r   (r_r),
      .i_k   (w_k),
      .o_f_c (w_f)
   );

   assign w_r_nx = r_l ^ w_f;

   // Next-state and datapath strobes
   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_step     = 1'b0;
      w_finish   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_nx = ROUND;
               w_load     = 1'b1;
            end
         end
         ROUND: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nx = DONE;
               w_finish   = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // State register with handshake flags decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_in_ready  <= (w_state_nx == IDLE);
         r_out_valid <= (w_state_nx == DONE);
         r_busy      <= (w_state_nx != IDLE);
      end
   end

   // Round datapath and key schedule registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_l        <= '0;
         r_r        <= '0;
         r_c        <= '0;
         r_d        <= '0;
         r_rnd      <= '0;
         r_dec      <= 1'b0;
         r_out_data <= '0;
      end else begin
         if (w_load) begin
            r_l   <= w_ip[63:32];
            r_r   <= w_ip[31:0];
            r_c   <= w_pc1[55:28];
            r_d   <= w_pc1[27:0];
            r_dec <= in_decrypt;
            r_rnd <= 5'd1;
         end else if (w_step) begin
            r_l   <= r_r;
            r_r   <= w_r_nx;
            r_c   <= w_c_nx;
            r_d   <= w_d_nx;
            r_rnd <= r_rnd + 5'd1;
         end
         // Final swap: output is FP({R16, L16})
         if (w_finish) r_out_data <= fp_perm({w_r_nx, r_r});
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
- Iterative DES encrypt/decrypt datapath. Executes one Feistel round per clock.
- Sits directly upstream of and around the eight S-box lookups: it produces each round's 48-bit expanded, key-mixed S-box indices and consumes the eight 4-bit substitution results.
- Also owns IP/FP, the key schedule (PC-1, rotations, PC-2), the P permutation and the valid/ready handshakes.
- Cipher mode is 64-bit ECB, one block per transaction.

Parameters:
- ROUNDS, 16, number of Feistel rounds executed. Only 16 is DES-compliant; smaller values are for debug only. Legal range is 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  engine can accept a request.
- in_decrypt  input  1  1 = decrypt, 0 = encrypt; sampled on accept.
- in_key  input  64  DES key. Parity bits (8,16,...,64) are ignored.
- in_data  input  64  plaintext or ciphertext block.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  64  result block.
- busy  output  1  high in ROUND or DONE.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, round counter=0, L/R/C/D registers=0.
- Bit order is FIPS 46-3 numbering: DES bit 1 = MSB ([63]); the S-box 6-bit index MSB = DES bit 1 of that group.
- State machine: IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load {L0,R0}=IP(in_data), {C0,D0}=PC1(in_key), latch mode, rnd=1, go to ROUND.
- ROUND (one round per cycle, rnd=1..ROUNDS):
  - f = P(Sbox(E(R) ^ K)), computed combinationally in the same cycle.
  - L<=R; R<=L^f.
  - Exit to DONE when rnd==ROUNDS.
- Key schedule:
  - SHIFTS = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt round i: rotate C,D left by SHIFTS[i]; K = PC2 of the rotated value. The rotation and the round use the same cycle; the rotated value is registered.
  - Decrypt round j: K = PC2 of the current C,D; then register C,D rotated right by SHIFTS[17-j]. Round 1 therefore uses K16 = PC2(C0D0).
- DONE:
  - out_data = FP({R,L}), i.e. the final swap is applied. out_data is registered on the ROUND->DONE transition.
  - out_valid=1, in_ready=0.
  - out_data stays stable until out_ready is seen; then out_valid drops and the engine returns to IDLE on the next edge.
- Latency: accept at cycle 0; rounds run in cycles 1..16; out_valid rises at cycle 17. With out_ready held high, the next accept is at cycle 18, giving a throughput of one block per 18 cycles.
- in_valid during ROUND/DONE is not accepted (in_ready=0). The input must be held by the producer per valid/ready rules.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation aborts immediately: the transaction is lost and no partial out_valid is produced.
- The ROUNDS<16 debug path uses the same schedule truncated; output is still FP({R,L}).

Decomposition:
- Shared package des_pkg contains:
  - permutation tables IP, FP, E, P, PC1, PC2 as constant index arrays;
  - the SHIFTS array;
  - permute functions that index arrays using DES bit numbering;
  - state enum IDLE/ROUND/DONE.
- One natural sub-module, des_f_function (combinational):
  - inputs R[31:0] and K[47:0]; E expansion and XOR;
  - eight S-box instances (s_box_1..s_box_8, existing), then P; output f[31:0].
- The FSM, key schedule and IP/FP live in des_round_engine.

Test Plan:
- Encrypt key 133457799BBCDFF1, data 0123456789ABCDEF -> out_data 85E813540F0AB405, out_valid at cycle 17 after accept.
- Decrypt key 133457799BBCDFF1, data 85E813540F0AB405 -> 0123456789ABCDEF. Encrypt key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE; next accept 1 cycle later.
- Back-to-back with in_valid and out_ready always high, 3 mixed encrypt/decrypt blocks -> accepts spaced exactly 18 cycles apart, all results correct.
- rst_n low asynchronously at round 8 -> out_valid=0, in_ready=1, busy=0 immediately. A subsequent request gives the correct FIPS vector result.
- Parity insensitivity: key 133457799BBCDFF1 with all parity bits flipped -> identical ciphertext 85E813540F0AB405.
